// File: rtl/game_stage_controller.sv
// game_stage_controller: top-level game sequencer. Walks the game through
// stage load, banner, play, respawn and clear phases. It keeps score and
// lives, and drives the monsters' enable and per-stage reload reset.
module game_stage_controller #(
  parameter int LAST_STAGE     = 4,
  parameter int START_LIVES    = 3,
  parameter int KILL_POINTS    = 10,
  parameter int STAGE_BONUS    = 100,
  parameter int LOAD_CYCLES    = 4,
  parameter int BANNER_FRAMES  = 90,
  parameter int CLEAR_FRAMES   = 60,
  parameter int RESPAWN_FRAMES = 45
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        start_key,
  input  logic        monster_died_pulse,
  input  logic        all_monsters_dead,
  input  logic        player_hit_pulse,
  output logic [2:0]  stage_num,
  output logic        monsters_enable,
  output logic        stage_resetN,
  output logic [15:0] score,
  output logic [2:0]  lives,
  output logic        show_banner,
  output logic        game_over,
  output logic        game_won
);

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE, LOAD, BANNER, PLAY, RESPAWN, CLEAR, OVER, WON
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       stage_q, stage_d;
  logic [15:0]      score_q, score_d;
  logic [2:0]       lives_q, lives_d;
  logic             mdp_prev_q;
  logic             en_q, srn_q, banner_q, over_q, won_q;

  logic             kill_edge;
  logic             frame_done;
  logic             score_clear;
  logic [15:0]      kill_add;
  logic [15:0]      bonus_add;
  logic [15:0]      stage_bonus;
  logic [2:0]       lives_dec;

  // Unsigned add clamped at the top of the 16-bit range.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign kill_edge   = monster_died_pulse && !mdp_prev_q &&
                       ((state_q == PLAY) || (state_q == RESPAWN) || (state_q == CLEAR));
  assign kill_add    = kill_edge ? 16'(KILL_POINTS) : 16'd0;
  assign stage_bonus = 16'(STAGE_BONUS) * {13'd0, stage_q};
  assign lives_dec   = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
  // A frame phase ends on the pulse that brings the counter to zero; the
  // counter is only loaded on entry, so an entry-cycle pulse never counts.
  assign frame_done  = (cnt_q == '0) || (startOfFrame && (cnt_q == CNT_W'(1)));

  // Next-state, counter, stage, lives and score decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    lives_d     = lives_q;
    bonus_add   = 16'd0;
    score_clear = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_key) begin
          score_clear = 1'b1;
          lives_d     = 3'(START_LIVES);
          stage_d     = 3'd1;
          cnt_d       = CNT_W'(LOAD_CYCLES - 1);
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(BANNER_FRAMES);
          state_d = BANNER;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      BANNER: begin
        if (frame_done) begin
          cnt_d   = '0;
          state_d = PLAY;
        end else if (startOfFrame) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PLAY: begin
        // A fatal hit beats a simultaneous clear; a non-fatal hit on the
        // clearing cycle costs a life but skips the respawn pause.
        if (player_hit_pulse && (lives_dec == 3'd0)) begin
          lives_d = lives_dec;
          state_d = OVER;
        end else if (all_monsters_dead) begin
          if (player_hit_pulse) lives_d = lives_dec;
          bonus_add = stage_bonus;
          cnt_d     = CNT_W'(CLEAR_FRAMES);
          state_d   = (stage_q == 3'(LAST_STAGE)) ? WON : CLEAR;
        end else if (player_hit_pulse) begin
          lives_d = lives_dec;
          cnt_d   = CNT_W'(RESPAWN_FRAMES);
          state_d = RESPAWN;
        end
      end
      RESPAWN: begin
        if (frame_done) begin
          cnt_d   = '0;
          state_d = PLAY;
        end else if (startOfFrame) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CLEAR: begin
        if (frame_done) begin
          stage_d = stage_q + 3'd1;
          cnt_d   = CNT_W'(LOAD_CYCLES - 1);
          state_d = LOAD;
        end else if (startOfFrame) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      OVER, WON: begin
        if (start_key) begin
          stage_d = 3'd0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    score_d = score_clear ? 16'd0 : sat_add(score_q, sat_add(kill_add, bonus_add));
  end

  // State, counters and registered outputs; outputs decode the next state so
  // they line up with the state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      stage_q    <= 3'd0;
      score_q    <= 16'd0;
      lives_q    <= 3'(START_LIVES);
      mdp_prev_q <= 1'b0;
      en_q       <= 1'b0;
      srn_q      <= 1'b1;
      banner_q   <= 1'b0;
      over_q     <= 1'b0;
      won_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stage_q    <= stage_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      mdp_prev_q <= monster_died_pulse;
      en_q       <= (state_d == PLAY);
      srn_q      <= (state_d != LOAD);
      banner_q   <= (state_d == BANNER);
      over_q     <= (state_d == OVER);
      won_q      <= (state_d == WON);
    end
  end

  assign stage_num       = stage_q;
  assign monsters_enable = en_q;
  assign stage_resetN    = srn_q;
  assign score           = score_q;
  assign lives           = lives_q;
  assign show_banner     = banner_q;
  assign game_over       = over_q;
  assign game_won        = won_q;

endmodule

// File: tb/tb_game_stage_controller.sv
// Scoreboard bench for game_stage_controller: stimulus pushes every expected
// output-vector change, plus how many cycles the previous vector lasted.
// The monitor pops one entry on each observed change.
module tb_game_stage_controller;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        start_key = 1'b0;
  logic        monster_died_pulse = 1'b0;
  logic        all_monsters_dead = 1'b0;
  logic        player_hit_pulse = 1'b0;
  logic [2:0]  stage_num;
  logic        monsters_enable;
  logic        stage_resetN;
  logic [15:0] score;
  logic [2:0]  lives;
  logic        show_banner;
  logic        game_over;
  logic        game_won;

  always #5 clk = ~clk;

  game_stage_controller dut (
    .clk                (clk),
    .resetN             (resetN),
    .startOfFrame       (startOfFrame),
    .start_key          (start_key),
    .monster_died_pulse (monster_died_pulse),
    .all_monsters_dead  (all_monsters_dead),
    .player_hit_pulse   (player_hit_pulse),
    .stage_num          (stage_num),
    .monsters_enable    (monsters_enable),
    .stage_resetN       (stage_resetN),
    .score              (score),
    .lives              (lives),
    .show_banner        (show_banner),
    .game_over          (game_over),
    .game_won           (game_won)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        en;
    logic        srn;
    logic [15:0] sc;
    logic [2:0]  lv;
    logic        bn;
    logic        ov;
    logic        wn;
  } ovec_t;

  ovec_t exp_q[$];
  int    dur_q[$];
  string name_q[$];

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_cyc = 0;
  bit    first = 1'b1;
  bit    done = 1'b0;
  ovec_t prev_v;
  ovec_t cur_v;
  ovec_t want_v;
  int    want_d;
  string want_n;

  function automatic string fmt(input ovec_t v);
    return $sformatf("st=%0d en=%0d srn=%0d sc=%0d lv=%0d bn=%0d ov=%0d wn=%0d",
                     v.st, v.en, v.srn, v.sc, v.lv, v.bn, v.ov, v.wn);
  endfunction

  // dur < 0 means the length of the previous output vector is not checked.
  task automatic ex(input string n, input int st, input int en, input int srn,
                    input int sc, input int lv, input int bn, input int ov,
                    input int wn, input int dur);
    ovec_t v;
    v.st  = 3'(st);
    v.en  = 1'(en);
    v.srn = 1'(srn);
    v.sc  = 16'(sc);
    v.lv  = 3'(lv);
    v.bn  = 1'(bn);
    v.ov  = 1'(ov);
    v.wn  = 1'(wn);
    exp_q.push_back(v);
    dur_q.push_back(dur);
    name_q.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each frame: three idle cycles then a one-cycle startOfFrame pulse, so a
  // phase of N frames entered on edge X ends on edge X+4N.
  task automatic frames(input int n);
    repeat (n) begin
      tick(); tick(); tick();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start_key = 1'b1;
    tick();
    start_key = 1'b0;
  endtask

  task automatic kill();
    monster_died_pulse = 1'b1;
    tick();
    monster_died_pulse = 1'b0;
    tick();
  endtask

  // Called right after the edge that entered LOAD.
  task automatic load_banner(input int st, input int sc, input int lv);
    ex("banner_enter", st, 0, 1, sc, lv, 1, 0, 0, 4);
    ex("play_enter",   st, 1, 1, sc, lv, 0, 0, 0, 360);
    repeat (4) tick();
    frames(90);
  endtask

  // Clear the stage (with a frame pulse on the clearing cycle, which must
  // not count toward the clear pause), then run into the next stage's play.
  task automatic clear_stage(input int st, input int sc, input int lv, input bit with_kill);
    if (st == 4) ex("won_enter", st, 0, 1, sc, lv, 0, 0, 1, -1);
    else         ex("clear_enter", st, 0, 1, sc, lv, 0, 0, 0, -1);
    all_monsters_dead  = 1'b1;
    startOfFrame       = 1'b1;
    monster_died_pulse = with_kill;
    tick();
    all_monsters_dead  = 1'b0;
    startOfFrame       = 1'b0;
    monster_died_pulse = 1'b0;
    if (st != 4) begin
      ex("load_enter", st + 1, 0, 0, sc, lv, 0, 0, 0, 240);
      frames(60);
      load_banner(st + 1, sc, lv);
    end
  endtask

  // Non-fatal hit in PLAY, then the respawn pause back to PLAY.
  task automatic respawn_hit(input int st, input int sc, input int lv_after);
    ex("respawn_enter", st, 0, 1, sc, lv_after, 0, 0, 0, -1);
    player_hit_pulse = 1'b1;
    tick();
    player_hit_pulse = 1'b0;
    ex("respawn_exit", st, 1, 1, sc, lv_after, 0, 0, 0, 180);
    frames(45);
  endtask

  // Monitor: compare every change of the output vector against the queue.
  always @(negedge clk) begin
    cyc = cyc + 1;
    cur_v.st  = stage_num;
    cur_v.en  = monsters_enable;
    cur_v.srn = stage_resetN;
    cur_v.sc  = score;
    cur_v.lv  = lives;
    cur_v.bn  = show_banner;
    cur_v.ov  = game_over;
    cur_v.wn  = game_won;
    if (first || (cur_v !== prev_v)) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_change: got %s, required no change", fmt(cur_v));
      end else begin
        want_v = exp_q.pop_front();
        want_d = dur_q.pop_front();
        want_n = name_q.pop_front();
        if ((cur_v !== want_v) || (want_d >= 0 && !first && (cyc - last_cyc) != want_d)) begin
          errors = errors + 1;
          $display("FAIL %s: got %s after %0d cycles, required %s after %0d cycles",
                   want_n, fmt(cur_v), cyc - last_cyc, fmt(want_v), want_d);
        end
      end
      prev_v   = cur_v;
      last_cyc = cyc;
      first    = 1'b0;
    end
    if (done || cyc > 50000) begin
      checks = checks + 1;
      if (!done) begin
        errors = errors + 1;
        $display("FAIL timeout: got %0d cycles, required completion", cyc);
      end else if (exp_q.size() != 0) begin
        errors = errors + 1;
        $display("FAIL missing_changes: got %0d pending, required 0 (next %s)",
                 exp_q.size(), name_q[0]);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    ex("reset_values", 0, 0, 1, 0, 3, 0, 0, 0, -1);
    repeat (3) tick();
    resetN = 1'b1;
    repeat (3) tick();

    // Game 1: kills, stage clear, hits down to game over.
    ex("start_load", 1, 0, 0, 0, 3, 0, 0, 0, -1);
    pulse_start();
    load_banner(1, 0, 3);
    ex("kill1", 1, 1, 1, 10, 3, 0, 0, 0, -1);
    kill();
    ex("kill2_wide", 1, 1, 1, 20, 3, 0, 0, 0, -1);
    monster_died_pulse = 1'b1;
    repeat (3) tick();
    monster_died_pulse = 1'b0;
    tick();
    ex("kill3", 1, 1, 1, 30, 3, 0, 0, 0, -1);
    kill();
    clear_stage(1, 130, 3, 1'b0);
    pulse_start();
    tick();
    ex("hit1", 2, 0, 1, 130, 2, 0, 0, 0, -1);
    player_hit_pulse = 1'b1;
    tick();
    player_hit_pulse = 1'b0;
    ex("kill_in_respawn", 2, 0, 1, 140, 2, 0, 0, 0, -1);
    monster_died_pulse = 1'b1;
    tick();
    monster_died_pulse = 1'b0;
    ex("respawn1_exit", 2, 1, 1, 140, 2, 0, 0, 0, 180);
    frames(45);
    respawn_hit(2, 140, 1);
    ex("hit3_over", 2, 0, 1, 140, 0, 0, 1, 0, -1);
    player_hit_pulse = 1'b1;
    tick();
    player_hit_pulse = 1'b0;
    repeat (5) tick();
    ex("over_to_idle", 0, 0, 1, 140, 0, 0, 0, 0, 6);
    pulse_start();
    repeat (3) tick();

    // Game 2: clear all stages, kill+clear together on stage 1, win.
    ex("g2_start", 1, 0, 0, 0, 3, 0, 0, 0, -1);
    pulse_start();
    load_banner(1, 0, 3);
    clear_stage(1, 110, 3, 1'b1);
    clear_stage(2, 310, 3, 1'b0);
    clear_stage(3, 610, 3, 1'b0);
    clear_stage(4, 1010, 3, 1'b0);
    repeat (10) tick();
    ex("won_to_idle", 0, 0, 1, 1010, 3, 0, 0, 0, 11);
    pulse_start();
    repeat (3) tick();

    // Game 3: fatal hit together with clear -> OVER, no bonus.
    ex("g3_start", 1, 0, 0, 0, 3, 0, 0, 0, -1);
    pulse_start();
    load_banner(1, 0, 3);
    respawn_hit(1, 0, 2);
    respawn_hit(1, 0, 1);
    ex("hit_dead_over", 1, 0, 1, 0, 0, 0, 1, 0, -1);
    player_hit_pulse  = 1'b1;
    all_monsters_dead = 1'b1;
    tick();
    player_hit_pulse  = 1'b0;
    all_monsters_dead = 1'b0;
    tick();
    ex("g3_idle", 0, 0, 1, 0, 0, 0, 0, 0, -1);
    pulse_start();
    repeat (3) tick();

    // Game 4: non-fatal hit with clear -> CLEAR, then reset mid-banner.
    ex("g4_start", 1, 0, 0, 0, 3, 0, 0, 0, -1);
    pulse_start();
    load_banner(1, 0, 3);
    respawn_hit(1, 0, 2);
    ex("hit_dead_clear", 1, 0, 1, 100, 1, 0, 0, 0, -1);
    player_hit_pulse  = 1'b1;
    all_monsters_dead = 1'b1;
    tick();
    player_hit_pulse  = 1'b0;
    all_monsters_dead = 1'b0;
    ex("g4_load2", 2, 0, 0, 100, 1, 0, 0, 0, 240);
    frames(60);
    ex("g4_banner2", 2, 0, 1, 100, 1, 1, 0, 0, 4);
    repeat (4) tick();
    frames(5);
    ex("reset_mid_banner", 0, 0, 1, 0, 3, 0, 0, 0, -1);
    resetN = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
    repeat (3) tick();

    // Game 5: score saturation.
    ex("g5_start", 1, 0, 0, 0, 3, 0, 0, 0, -1);
    pulse_start();
    load_banner(1, 0, 3);
    for (int i = 1; i <= 6553; i++) begin
      ex("kill_count", 1, 1, 1, 10 * i, 3, 0, 0, 0, -1);
      kill();
    end
    ex("kill_saturate", 1, 1, 1, 65535, 3, 0, 0, 0, -1);
    kill();
    kill();
    ex("clear_saturated", 1, 0, 1, 65535, 3, 0, 0, 0, -1);
    all_monsters_dead = 1'b1;
    tick();
    all_monsters_dead = 1'b0;
    repeat (5) tick();
    done = 1'b1;
  end

endmodule
